// File: rtl/audio_osc_core.sv
`default_nettype none
// ============================================================================
// Module   : audio_osc_core
// Purpose  : Phase-accumulator oscillator emitting sine, square and sawtooth
//            samples of one fixed note behind a shared ready/valid handshake.
// Revision : 1.0 - initial release
// ============================================================================
module audio_osc_core #(
   parameter int  width_p         = 24,
   parameter real sampling_freq_p = 44100.0,
   parameter real note_freq_p     = 440.0
) (
   input  logic                      clk_i,
   input  logic                      reset_ni,
   input  logic                      ready_i,
   output logic                      valid_o,
   output logic signed [width_p-1:0] sine_o,
   output logic signed [width_p-1:0] square_o,
   output logic signed [width_p-1:0] saw_o
);

   localparam real c_pi    = 3.14159265358979323846;
   localparam real c_amp_r = (2.0 ** (width_p - 1)) - 1.0;
   localparam logic [31:0] c_inc =
      32'($rtoi(note_freq_p / sampling_freq_p * 4294967296.0 + 0.5));
   localparam logic signed [width_p-1:0] c_amp     = {1'b0, {(width_p-1){1'b1}}};
   localparam logic signed [width_p-1:0] c_amp_neg = -c_amp;

   // Quarter-wave table sampled at half-index points so mirroring is exact.
   logic [width_p-1:0] w_lut [256];

   for (genvar gi = 0; gi < 256; gi++) begin : g_lut
      localparam int c_q = $rtoi(c_amp_r * $sin(2.0 * c_pi * (gi + 0.5) / 1024.0) + 0.5);
      assign w_lut[gi] = width_p'(c_q);
   end

   logic                      r_valid;
   logic [31:0]               r_phase;
   logic signed [width_p-1:0] r_sine;
   logic signed [width_p-1:0] r_square;
   logic signed [width_p-1:0] r_saw;

   logic                      w_adv;
   logic [31:0]               w_phase_nxt;
   logic [7:0]                w_k;
   logic [width_p-1:0]        w_mag;
   logic [width_p-1:0]        w_sine;
   logic [width_p-1:0]        w_square;
   logic [width_p-1:0]        w_saw;

   // The very first edge after reset loads f(0); later edges need a handshake.
   always_comb begin
      w_adv       = !r_valid || ready_i;
      w_phase_nxt = r_valid ? (r_phase + c_inc) : 32'd0;
      w_k         = w_phase_nxt[30] ? ~w_phase_nxt[29:22] : w_phase_nxt[29:22];
      w_mag       = w_lut[w_k];
      w_sine      = w_phase_nxt[31] ? -w_mag : w_mag;
      w_square    = w_phase_nxt[31] ? c_amp_neg : c_amp;
      w_saw       = {~w_phase_nxt[31], w_phase_nxt[30:32-width_p]};
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_valid  <= 1'b0;
         r_phase  <= 32'd0;
         r_sine   <= '0;
         r_square <= '0;
         r_saw    <= '0;
      end else if (w_adv) begin
         r_valid  <= 1'b1;
         r_phase  <= w_phase_nxt;
         r_sine   <= w_sine;
         r_square <= w_square;
         r_saw    <= w_saw;
      end
   end

   assign valid_o  = r_valid;
   assign sine_o   = r_sine;
   assign square_o = r_square;
   assign saw_o    = r_saw;

endmodule
`default_nettype wire

// File: tb/tb_audio_osc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_osc_core
// Purpose  : Randomized self-checking bench for audio_osc_core against a
//            phase-level arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_osc_core;

   localparam int     W     = 24;
   localparam longint INC   = 42852281;
   localparam longint AMP   = 8388607;
   localparam longint HALF  = 64'd2147483648;
   localparam longint MOD   = 64'd4294967296;

   logic                clk_i;
   logic                reset_ni;
   logic                ready_i;
   logic                valid_o;
   logic signed [W-1:0] sine_o;
   logic signed [W-1:0] square_o;
   logic signed [W-1:0] saw_o;

   int     n_checks;
   int     n_errors;
   bit     m_valid;
   longint m_phase;

   audio_osc_core #(
      .width_p         (W),
      .sampling_freq_p (44100.0),
      .note_freq_p     (440.0)
   ) u_dut (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .ready_i  (ready_i),
      .valid_o  (valid_o),
      .sine_o   (sine_o),
      .square_o (square_o),
      .saw_o    (saw_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1);
   end

   task automatic check(input string tag, input longint obs, input longint exp,
                        input longint tol = 0);
      longint d;
      d = obs - exp;
      n_checks++;
      if (d > tol || d < -tol) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   // Reference sine: A*sin at the centre of the 1/1024-turn bin holding the phase.
   function automatic longint ref_sine(input longint p);
      real x;
      x = real'(AMP) * $sin(2.0 * $acos(-1.0) * (real'(p >> 22) + 0.5) / 1024.0);
      return (x >= 0.0) ? longint'($rtoi(x + 0.5)) : -longint'($rtoi(-x + 0.5));
   endfunction

   function automatic longint ref_saw(input longint p);
      return (p >> (32 - W)) - (64'd1 << (W - 1));
   endfunction

   function automatic longint ref_square(input longint p);
      return (p < HALF) ? AMP : -AMP;
   endfunction

   task automatic check_all();
      check("valid", longint'(valid_o), longint'(m_valid));
      if (m_valid) begin
         check("square", longint'(square_o), ref_square(m_phase));
         check("saw",    longint'(saw_o),    ref_saw(m_phase));
         check("sine",   longint'(sine_o),   ref_sine(m_phase), 1);
      end else begin
         check("square_rst", longint'(square_o), 0);
         check("saw_rst",    longint'(saw_o),    0);
         check("sine_rst",   longint'(sine_o),   0);
      end
   endtask

   // Called away from the clock edge; returns 1 time unit after the edge.
   task automatic step(input bit rdy);
      ready_i = rdy;
      @(posedge clk_i);
      if (!m_valid) begin
         m_valid = 1'b1;
      end else if (rdy) begin
         m_phase = (m_phase + INC) % MOD;
      end
      #1;
      check_all();
   endtask

   task automatic async_reset(input int dly);
      @(posedge clk_i);
      #(dly);
      ready_i  = 1'b1;
      reset_ni = 1'b0;
      m_valid  = 1'b0;
      m_phase  = 0;
      #1;
      check_all();
      #1;
      reset_ni = 1'b1;
   endtask

   task automatic check_first_sample();
      check("first_square", longint'(square_o), 8388607);
      check("first_saw",    longint'(saw_o),    -8388608);
      check("first_sine",   longint'(sine_o),   25736, 1);
   endtask

   initial begin
      longint prev_saw;
      longint peak;
      longint s;

      n_checks = 0;
      n_errors = 0;
      m_valid  = 1'b0;
      m_phase  = 0;
      reset_ni = 1'b0;
      ready_i  = 1'b0;

      repeat (3) @(posedge clk_i);
      #1;
      check_all();
      reset_ni = 1'b1;

      step(1'b0);
      check_first_sample();

      repeat (20) step(1'b0);
      check_first_sample();
      step(1'b1);
      check("adv_changed", longint'(saw_o != -24'sd8388608), 1);

      repeat (300) step(1'($urandom_range(0, 1)));

      async_reset(2);
      step(1'b1);
      check_first_sample();

      prev_saw = longint'(saw_o);
      peak     = 0;
      for (int n = 1; n <= 1000; n++) begin
         step(1'b1);
         s = longint'(sine_o);
         if (n == 50)  check("square_t50", longint'(square_o), AMP);
         if (n == 51)  check("square_t51", longint'(square_o), -AMP);
         if (n <= 100) check("saw_rising", longint'(longint'(saw_o) > prev_saw), 1);
         if (n == 101) check("saw_wrap",   longint'(longint'(saw_o) < -64'sd8000000), 1);
         check("sine_bound", longint'(s <= AMP && s >= -AMP), 1);
         if (m_phase < HALF) check("sine_pos", longint'(s > 0), 1);
         else                check("sine_neg", longint'(s < 0), 1);
         if (s > peak)  peak = s;
         if (-s > peak) peak = -s;
         prev_saw = longint'(saw_o);
      end
      check("sine_peak", longint'(peak >= 8388500), 1);

      repeat (200) step(1'($urandom_range(0, 1)));
      async_reset(int'($urandom_range(1, 6)));
      step(1'($urandom_range(0, 1)));
      check_first_sample();
      repeat (100) step(1'($urandom_range(0, 1)));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
